// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, interrupt vector address
// and the interrupt-entry FSM state encoding.
package cpu_pkg;

  localparam int DEF_PC_W = 32;
  localparam int INT_VEC  = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_SAVE = 2'd1,
    INT_WAIT = 2'd2,
    INT_JUMP = 2'd3
  } int_state_t;

endpackage

// File: rtl/pc_ctrl_int_seq.sv
// Interrupt entry sequencer for the fetch stage.
// Ports: clk, rst, [int_mask], int_req, stall, branch_out, ret,
// vec_valid, vec_data, pc in; hold, jump, vec, int_active,
// int_save, int_save_pc out. Optional int_mask under INT_MASK_EN.
module int_seq
  import cpu_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic            clk,
  input  logic            rst,
`ifdef INT_MASK_EN
  input  logic            int_mask,
`endif
  input  logic            int_req,
  input  logic            stall,
  input  logic            branch_out,
  input  logic            ret,
  input  logic            vec_valid,
  input  logic [PC_W-1:0] vec_data,
  input  logic [PC_W-1:0] pc,
  output logic            hold,
  output logic            jump,
  output logic [PC_W-1:0] vec,
  output logic            int_active,
  output logic            int_save,
  output logic [PC_W-1:0] int_save_pc
);

  int_state_t state, state_nxt;
  logic req_q;
  logic pending;
  logic rise;
  logic masked;
  logic go;

`ifdef INT_MASK_EN
  assign masked = int_mask;
`else
  assign masked = 1'b0;
`endif

  assign rise = int_req & ~req_q;

  // A same-cycle edge counts as pending so entry is not
  // delayed by a cycle. On the go cycle the PC is held so the
  // address just fetched (and later flushed) is the one saved.
  assign go = (state == IDLE) & (pending | rise) & ~masked &
              ~stall & ~branch_out & ~ret;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (go) state_nxt = INT_SAVE;
      INT_SAVE: state_nxt = INT_WAIT;
      INT_WAIT: if (vec_valid) state_nxt = INT_JUMP;
      INT_JUMP: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      pending     <= 1'b0;
      vec         <= '0;
      int_save_pc <= '0;
    end else begin
      state <= state_nxt;
      req_q <= int_req;
      if (go)
        pending <= 1'b0;
      else if (state == IDLE && rise)
        pending <= 1'b1;
      if (go)
        int_save_pc <= pc;
      if (state == INT_WAIT && vec_valid)
        vec <= vec_data;
    end
  end

  assign hold       = go | (state == INT_SAVE) |
                      (state == INT_WAIT);
  assign jump       = (state == INT_JUMP);
  assign int_active = (state != IDLE);
  assign int_save   = (state == INT_SAVE);

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage program counter: next-PC mux and PC register.
// Ports: clk, rst, stall, inst_32, branch_out/branch_pc, ret/ret_pc,
// int_req, vec_valid/vec_data in; pc, int_active, int_save,
// int_save_pc out. Optional int_mask input under INT_MASK_EN.
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
`ifdef INT_MASK_EN
  input  logic            int_mask,
`endif
  input  logic            stall,
  input  logic            inst_32,
  input  logic            branch_out,
  input  logic [PC_W-1:0] branch_pc,
  input  logic            ret,
  input  logic [PC_W-1:0] ret_pc,
  input  logic            int_req,
  input  logic            vec_valid,
  input  logic [PC_W-1:0] vec_data,
  output logic [PC_W-1:0] pc,
  output logic            int_active,
  output logic            int_save,
  output logic [PC_W-1:0] int_save_pc
);

  logic            hold;
  logic            jump;
  logic [PC_W-1:0] vec;
  logic [PC_W-1:0] inc;
  logic [PC_W-1:0] pc_nxt;

  int_seq #(.PC_W(PC_W)) u_int_seq (
    .clk         (clk),
    .rst         (rst),
`ifdef INT_MASK_EN
    .int_mask    (int_mask),
`endif
    .int_req     (int_req),
    .stall       (stall),
    .branch_out  (branch_out),
    .ret         (ret),
    .vec_valid   (vec_valid),
    .vec_data    (vec_data),
    .pc          (pc),
    .hold        (hold),
    .jump        (jump),
    .vec         (vec),
    .int_active  (int_active),
    .int_save    (int_save),
    .int_save_pc (int_save_pc)
  );

  assign inc = {{(PC_W-2){1'b0}}, inst_32, ~inst_32};

  // Sequencer hold also masks redirects while an entry is
  // in progress; the pipeline is being flushed anyway.
  always_comb begin
    pc_nxt = pc + inc;
    priority case (1'b1)
      jump:       pc_nxt = vec;
      hold:       pc_nxt = pc;
      branch_out: pc_nxt = branch_pc;
      ret:        pc_nxt = ret_pc;
      stall:      pc_nxt = pc;
      default:    pc_nxt = pc + inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_nxt;
  end

endmodule
